// File: rtl/gpio_bank_pkg.sv
// Shared register map and register-select decode for the GPIO bank.
// Optional edge-IRQ feature is controlled by the GPIO_IRQ_EN macro in gpio_bank.sv.
package gpio_bank_pkg;

    localparam int unsigned GPIO_WIDTH_MAX = 32;

    localparam logic [4:0] GPIO_OFF_DATA_OUT = 5'h00;
    localparam logic [4:0] GPIO_OFF_DIR      = 5'h04;
    localparam logic [4:0] GPIO_OFF_DATA_IN  = 5'h08;
    localparam logic [4:0] GPIO_OFF_IRQ_EN   = 5'h0C;
    localparam logic [4:0] GPIO_OFF_IRQ_STAT = 5'h10;
    localparam logic [4:0] GPIO_OFF_IRQ_POL  = 5'h14;

    typedef enum logic [2:0] {
        SEL_DATA_OUT,
        SEL_DIR,
        SEL_DATA_IN,
        SEL_IRQ_EN,
        SEL_IRQ_STAT,
        SEL_IRQ_POL,
        SEL_NONE
    } reg_sel_e;

    // Byte-lane bits [1:0] of the offset are ignored, so decode on the word index only.
    function automatic reg_sel_e decode_reg(input logic [2:0] word);
        reg_sel_e sel;
        case (word)
            GPIO_OFF_DATA_OUT[4:2]: sel = SEL_DATA_OUT;
            GPIO_OFF_DIR[4:2]:      sel = SEL_DIR;
            GPIO_OFF_DATA_IN[4:2]:  sel = SEL_DATA_IN;
            GPIO_OFF_IRQ_EN[4:2]:   sel = SEL_IRQ_EN;
            GPIO_OFF_IRQ_STAT[4:2]: sel = SEL_IRQ_STAT;
            GPIO_OFF_IRQ_POL[4:2]:  sel = SEL_IRQ_POL;
            default:                sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit input synchroniser: STAGES-deep flop chain, async active-low reset.
// Shared with the UART receiver.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], i_D};
        end
    end

    assign o_Q = chain[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: register file, read mux, input sync, edge detection and IRQ combine.
// Define GPIO_IRQ_EN to build the IRQ_EN/IRQ_STAT/IRQ_POL registers and o_IRQ logic.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_CE,
    input  logic             i_WE,
    input  logic [4:0]       i_ADDR,
    input  logic [31:0]      i_WDATA,
    input  logic             i_REQ,
    output logic             o_GNT,
    output logic [31:0]      o_RDATA,
    input  logic [WIDTH-1:0] i_GPIO_IN,
    output logic [WIDTH-1:0] o_GPIO_OUT,
    output logic [WIDTH-1:0] o_GPIO_OE,
    output logic             o_IRQ
);

    logic             wr_en;
    logic             rd_en;
    reg_sel_e         sel;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] rd_val;
    logic             unused_bits;

    assign o_GNT       = i_REQ & i_CE;
    assign wr_en       = o_GNT & i_WE;
    assign rd_en       = o_GNT & ~i_WE;
    assign sel         = decode_reg(i_ADDR[4:2]);
    assign wdata       = i_WDATA[WIDTH-1:0];
    assign unused_bits = ^{i_ADDR[1:0], i_WDATA};

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .i_D    (i_GPIO_IN),
        .o_Q    (data_in)
    );

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            data_out <= '0;
            dir      <= '0;
        end else if (wr_en) begin
            if (sel == SEL_DATA_OUT) data_out <= wdata;
            if (sel == SEL_DIR)      dir      <= wdata;
        end
    end

    assign o_GPIO_OUT = data_out;
    assign o_GPIO_OE  = dir;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_stat;
    logic [WIDTH-1:0] irq_pol;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] stat_clr;

    assign edge_evt = (data_in & ~prev & ~irq_pol) | (~data_in & prev & irq_pol);
    assign stat_clr = (wr_en && sel == SEL_IRQ_STAT) ? wdata : '0;

    // Set is OR-ed after the clear so a same-cycle event beats the w1c.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            prev     <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            irq_pol  <= '0;
        end else begin
            prev     <= data_in;
            irq_stat <= (irq_stat & ~stat_clr) | edge_evt;
            if (wr_en && sel == SEL_IRQ_EN)  irq_en  <= wdata;
            if (wr_en && sel == SEL_IRQ_POL) irq_pol <= wdata;
        end
    end

    assign o_IRQ = |(irq_stat & irq_en);
`else
    assign o_IRQ = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (rd_en) begin
            case (sel)
                SEL_DATA_OUT: rd_val = data_out;
                SEL_DIR:      rd_val = dir;
                SEL_DATA_IN:  rd_val = data_in;
`ifdef GPIO_IRQ_EN
                SEL_IRQ_EN:   rd_val = irq_en;
                SEL_IRQ_STAT: rd_val = irq_stat;
                SEL_IRQ_POL:  rd_val = irq_pol;
`endif
                default:      rd_val = '0;
            endcase
        end
    end

    always_comb begin
        o_RDATA              = '0;
        o_RDATA[WIDTH-1:0]   = rd_val;
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (WIDTH=8 and WIDTH=4 instances sharing one bus).
// Expectations follow GPIO_IRQ_EN the same way the design does.
module tb_gpio_bank;

    localparam int S = 2;

`ifdef GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, we, req;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  pad;

    logic        gnt8, irq8, gnt4, irq4;
    logic [31:0] rdata8, rdata4;
    logic [7:0]  out8, oe8;
    logic [3:0]  out4, oe4;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_CE(ce), .i_WE(we), .i_ADDR(addr),
        .i_WDATA(wdata), .i_REQ(req), .o_GNT(gnt8), .o_RDATA(rdata8),
        .i_GPIO_IN(pad), .o_GPIO_OUT(out8), .o_GPIO_OE(oe8), .o_IRQ(irq8)
    );

    gpio_bank #(.WIDTH(4), .SYNC_STAGES(S)) dut4 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_CE(ce), .i_WE(we), .i_ADDR(addr),
        .i_WDATA(wdata), .i_REQ(req), .o_GNT(gnt4), .o_RDATA(rdata4),
        .i_GPIO_IN(pad[3:0]), .o_GPIO_OUT(out4), .o_GPIO_OE(oe4), .o_IRQ(irq4)
    );

    // Reference model: register values plus a history of pad samples, one per clock edge.
    logic [7:0] m_out, m_dir, m_ien, m_stat, m_pol;
    logic [7:0] hist[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] m_sync();
        return hist[hist.size() - S];
    endfunction

    function automatic logic [7:0] m_prev();
        return hist[hist.size() - S - 1];
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a, input int w);
        logic [7:0]  v;
        logic [4:0]  off;
        logic [31:0] mask;
        off  = {a[4:2], 2'b00};
        mask = (32'h1 << w) - 32'h1;
        case (off)
            5'h00:   v = m_out;
            5'h04:   v = m_dir;
            5'h08:   v = m_sync();
            5'h0C:   v = IRQ_ON ? m_ien  : 8'h00;
            5'h10:   v = IRQ_ON ? m_stat : 8'h00;
            5'h14:   v = IRQ_ON ? m_pol  : 8'h00;
            default: v = 8'h00;
        endcase
        return {24'h0, v} & mask;
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_ien = '0; m_stat = '0; m_pol = '0;
        hist.delete();
        repeat (S + 1) hist.push_back(8'h00);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; the model commits using the bus inputs held across the edge.
    task automatic tick();
        logic [7:0] sy, pv, ev, clr;
        logic [4:0] off;
        sy  = m_sync();
        pv  = m_prev();
        ev  = '0;
        clr = '0;
        for (int k = 0; k < 8; k++) begin
            if (m_pol[k]) ev[k] = !sy[k] && pv[k];
            else          ev[k] = sy[k] && !pv[k];
        end
        if (req && ce && we) begin
            off = {addr[4:2], 2'b00};
            case (off)
                5'h00: m_out = wdata[7:0];
                5'h04: m_dir = wdata[7:0];
                5'h0C: m_ien = wdata[7:0];
                5'h10: clr   = wdata[7:0];
                5'h14: m_pol = wdata[7:0];
                default: ;
            endcase
        end
        if (IRQ_ON) m_stat = (m_stat & ~clr) | ev;
        else begin
            m_stat = '0; m_ien = '0; m_pol = '0;
        end
        @(posedge clk);
        hist.push_back(pad);
        if (hist.size() > 16) void'(hist.pop_front());
        #1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".out8"}, {24'h0, out8}, {24'h0, m_out});
        chk({tag, ".oe8"},  {24'h0, oe8},  {24'h0, m_dir});
        chk({tag, ".irq8"}, {31'h0, irq8}, {31'h0, IRQ_ON && |(m_stat & m_ien)});
        chk({tag, ".out4"}, {28'h0, out4}, {28'h0, m_out[3:0]});
        chk({tag, ".oe4"},  {28'h0, oe4},  {28'h0, m_dir[3:0]});
        chk({tag, ".irq4"}, {31'h0, irq4}, {31'h0, IRQ_ON && |(m_stat[3:0] & m_ien[3:0])});
    endtask

    task automatic rd(input logic [4:0] a, input string tag);
        req = 1'b1; ce = 1'b1; we = 1'b0; addr = a;
        #1;
        chk({tag, ".gnt"},   {31'h0, gnt8}, 32'h1);
        chk({tag, ".rd8"},   rdata8, mread(a, 8));
        chk({tag, ".rd4"},   rdata4, mread(a, 4));
        req = 1'b0;
        #1;
        chk({tag, ".idle"},  rdata8, 32'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        req = 1'b1; ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; req = 1'b0;
        addr = '0; wdata = '0; pad = '0;
        model_reset();
        #12;
        chk("rst.out", {24'h0, out8}, 32'h0);
        chk("rst.oe",  {24'h0, oe8},  32'h0);
        chk("rst.irq", {31'h0, irq8}, 32'h0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) rd(5'(i * 4), "rst.reg");

        // Direction and data writes visible on pads after one edge.
        wr(5'h04, 32'hF0);
        wr(5'h00, 32'h3C);
        chk("wr.oe",  {24'h0, oe8},  32'hF0);
        chk("wr.out", {24'h0, out8}, 32'h3C);
        check_outs("wr");
        rd(5'h04, "rd.dir");
        rd(5'h00, "rd.out");
        chk("rd.dir.const", rdata8, 32'h0);  // bus idle after rd
        req = 1'b1; ce = 1'b1; we = 1'b0; addr = 5'h06; #1;
        chk("rd.dir.bytelane", rdata8, 32'hF0);
        req = 1'b0;

        // Synchroniser latency.
        pad = 8'h81;
        tick();
        req = 1'b1; ce = 1'b1; we = 1'b0; addr = 5'h08; #1;
        chk("sync.lat1", rdata8, 32'h00);
        req = 1'b0;
        tick();
        req = 1'b1; addr = 5'h08; #1;
        chk("sync.lat2", rdata8, 32'h81);
        req = 1'b0;
        rd(5'h08, "sync.model");
        tick();

`ifdef GPIO_IRQ_EN
        pad = 8'h00;
        repeat (4) tick();
        wr(5'h10, 32'hFF);
        wr(5'h14, 32'h00);
        wr(5'h0C, 32'h01);
        rd(5'h10, "irq.clear");
        pad = 8'h01;
        repeat (S + 1) tick();
        req = 1'b1; ce = 1'b1; we = 1'b0; addr = 5'h10; #1;
        chk("irq.stat", rdata8, 32'h01);
        chk("irq.line", {31'h0, irq8}, 32'h1);
        req = 1'b0;
        wr(5'h10, 32'h01);
        chk("irq.w1c", {31'h0, irq8}, 32'h0);
        check_outs("irq");

        wr(5'h14, 32'h02);
        pad = 8'h03;
        repeat (4) tick();
        wr(5'h10, 32'hFF);
        pad = 8'h01;
        tick();
        tick();
        wr(5'h10, 32'h02);
        req = 1'b1; ce = 1'b1; we = 1'b0; addr = 5'h10; #1;
        chk("irq.setwins", rdata8 & 32'h02, 32'h02);
        req = 1'b0;
        rd(5'h10, "irq.setwins.model");
`endif

        // Upper register bits and unmapped offsets.
        wr(5'h00, 32'hFFFF_FFFF);
        req = 1'b1; ce = 1'b1; we = 1'b0; addr = 5'h00; #1;
        chk("mask.w4", rdata4, 32'h0000_000F);
        chk("mask.w8", rdata8, 32'h0000_00FF);
        req = 1'b0;
        wr(5'h1C, 32'hDEAD_BEEF);
        rd(5'h1C, "unmapped.1c");
        rd(5'h18, "unmapped.18");
        rd(5'h10, "stat.build");
        check_outs("mask");

        // Ungranted write must not commit.
        req = 1'b1; ce = 1'b0; we = 1'b1; addr = 5'h00; wdata = 32'h55;
        #1;
        chk("nogrant.gnt", {31'h0, gnt8}, 32'h0);
        tick();
        req = 1'b0; we = 1'b0; ce = 1'b0;
        check_outs("nogrant");

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: rd(5'($urandom_range(0, 7) * 4), "rand.rd");
                1: begin
                    wr(5'($urandom_range(0, 7) * 4), $urandom);
                    check_outs("rand.wr");
                end
                2: begin
                    pad = 8'($urandom);
                    tick();
                    check_outs("rand.pad");
                end
                default: begin
                    req = 1'b1; ce = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
                    addr = 5'($urandom); wdata = $urandom;
                    tick();
                    req = 1'b0; we = 1'b0;
                    check_outs("rand.bus");
                end
            endcase
        end

        // Mid-run asynchronous reset.
        wr(5'h00, 32'hA5);
        wr(5'h04, 32'h5A);
        chk("arst.pre", {24'h0, out8}, 32'hA5);
        rst_n = 1'b0;
        #1;
        chk("arst.out", {24'h0, out8}, 32'h0);
        chk("arst.oe",  {24'h0, oe8},  32'h0);
        chk("arst.irq", {31'h0, irq8}, 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        pad = 8'h0F;
        repeat (S + 2) tick();
        rd(5'h10, "arst.edge");
        rd(5'h08, "arst.datain");
        check_outs("arst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
